// File: rtl/chip8_alu_seq.sv
// chip8_alu_seq: registered CHIP-8 8XYn ALU with a valid/ready request side
// and a multi-cycle double-dabble BCD converter for FX33.
//
// Handshake: a request is accepted on a rising clk edge where start=1 and
// ready=1. op/x/y are sampled only at that edge. A start seen while ready=0
// is dropped and is not queued. Each accepted op produces exactly one
// result_valid pulse. Single-cycle ops pulse in the cycle after the accept
// edge. BCD pulses WIDTH cycles after the accept edge.
//
// Ports:
//   clk, rst_n     rising-edge clock, asynchronous active-low reset
//   start, op, x, y   request and its operands
//   ready          block can accept a request this cycle
//   result_valid   one-cycle pulse; result/flag/bcd/err are valid
//   result, flag   ALU result and the value for VF
//   flag_we        VF write strobe, qualified by result_valid
//   bcd            BCD digits of x, most significant digit in the top nibble
//   err            illegal op, qualified by result_valid
//   dbg_state      current FSM state (0=IDLE, 1=BCD_RUN)
module chip8_alu_seq #(
  parameter int WIDTH          = 8,
  parameter int DIGITS         = 3,
  parameter int SHIFT_SRC_Y    = 0,
  parameter int VF_RESET_LOGIC = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [3:0]            op,
  input  logic [WIDTH-1:0]      x,
  input  logic [WIDTH-1:0]      y,
  output logic                  ready,
  output logic                  result_valid,
  output logic [WIDTH-1:0]      result,
  output logic                  flag,
  output logic                  flag_we,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  err,
  output logic                  dbg_state
);

  localparam int SRW = 4*DIGITS + WIDTH;
  localparam int CW  = $clog2(WIDTH + 1);

  typedef enum logic {
    S_IDLE    = 1'b0,
    S_BCD_RUN = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [SRW-1:0]       sr_q, sr_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic                 flag_q, flag_d;
  logic                 flag_we_q, flag_we_d;
  logic                 valid_q, valid_d;
  logic [4*DIGITS-1:0]  bcd_q, bcd_d;
  logic                 err_q, err_d;

  logic [WIDTH:0]       sum;
  logic [WIDTH-1:0]     shift_src;
  logic [SRW-1:0]       dab;
  logic [SRW-1:0]       dab_sh;

  assign sum       = {1'b0, x} + {1'b0, y};
  assign shift_src = (SHIFT_SRC_Y != 0) ? y : x;

  // One double-dabble step: the BCD digits live above the binary part;
  // correct every digit >= 5 by +3, then shift the whole register left.
  always_comb begin
    dab = sr_q;
    for (int d = 0; d < DIGITS; d++) begin
      if (dab[WIDTH+4*d +: 4] >= 4'd5)
        dab[WIDTH+4*d +: 4] = dab[WIDTH+4*d +: 4] + 4'd3;
    end
    dab_sh = {dab[SRW-2:0], 1'b0};
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sr_d      = sr_q;
    result_d  = result_q;
    flag_d    = flag_q;
    flag_we_d = 1'b0;
    valid_d   = 1'b0;
    bcd_d     = bcd_q;
    err_d     = err_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          valid_d = 1'b1;
          err_d   = 1'b0;
          case (op)
            4'd0: result_d = y;
            4'd1, 4'd2, 4'd3: begin
              case (op)
                4'd1:    result_d = x | y;
                4'd2:    result_d = x & y;
                default: result_d = x ^ y;
              endcase
              if (VF_RESET_LOGIC != 0) begin
                flag_d    = 1'b0;
                flag_we_d = 1'b1;
              end
            end
            4'd4: begin
              result_d  = sum[WIDTH-1:0];
              flag_d    = sum[WIDTH];
              flag_we_d = 1'b1;
            end
            4'd5: begin
              result_d  = x - y;
              flag_d    = (x >= y);
              flag_we_d = 1'b1;
            end
            4'd6: begin
              result_d  = shift_src >> 1;
              flag_d    = shift_src[0];
              flag_we_d = 1'b1;
            end
            4'd7: begin
              result_d  = shift_src << 1;
              flag_d    = shift_src[WIDTH-1];
              flag_we_d = 1'b1;
            end
            4'd8: begin
              result_d  = y - x;
              flag_d    = (y >= x);
              flag_we_d = 1'b1;
            end
            4'd9: begin
              // No pulse now; err keeps its old value until the BCD result.
              valid_d = 1'b0;
              err_d   = err_q;
              sr_d    = {{(4*DIGITS){1'b0}}, x};
              cnt_d   = '0;
              state_d = S_BCD_RUN;
            end
            default: begin
              result_d = '0;
              err_d    = 1'b1;
            end
          endcase
        end
      end
      S_BCD_RUN: begin
        sr_d  = dab_sh;
        cnt_d = cnt_q + CW'(1);
        // The last iteration's output is captured directly so the pulse
        // lands exactly WIDTH cycles after the accept edge.
        if (cnt_q == CW'(WIDTH - 1)) begin
          bcd_d   = dab_sh[SRW-1 -: 4*DIGITS];
          valid_d = 1'b1;
          err_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      sr_q      <= '0;
      result_q  <= '0;
      flag_q    <= 1'b0;
      flag_we_q <= 1'b0;
      valid_q   <= 1'b0;
      bcd_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sr_q      <= sr_d;
      result_q  <= result_d;
      flag_q    <= flag_d;
      flag_we_q <= flag_we_d;
      valid_q   <= valid_d;
      bcd_q     <= bcd_d;
      err_q     <= err_d;
    end
  end

  assign ready        = (state_q == S_IDLE);
  assign result_valid = valid_q;
  assign result       = result_q;
  assign flag         = flag_q;
  assign flag_we      = flag_we_q;
  assign bcd          = bcd_q;
  assign err          = err_q;
  assign dbg_state    = state_q;

endmodule
